// File: rtl/mem_ctrl.sv
// Byte-wide memory controller: arbitrates MEM burst requests and IF fetches onto a single-port RAM.
// Optional performance counters are enabled with `define MEM_CTRL_PERF_EN.
module mem_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mem_rw_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [7:0]        mem_data_i,
    input  logic              mem_flag_i,
    output logic              mem_r_o,
    output logic [7:0]        mem_data_o,
    input  logic              if_rw_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_r_o,
    output logic [7:0]        if_data_o,
    output logic              if_busy_o,
    input  logic [7:0]        ram_din_i,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic [7:0]        ram_dout_o,
    output logic              ram_wr_o,
    output logic [CNT_W-1:0]  perf_rd_o,
    output logic [CNT_W-1:0]  perf_wr_o,
    output logic [CNT_W-1:0]  perf_conf_o
);

    logic              lock_q;
    logic              tag1_v_q, tag1_if_q;
    logic              tag2_v_q, tag2_if_q;
    logic              mem_r_q, if_r_q;
    logic [7:0]        mem_data_q, if_data_q;
    logic [ADDR_W-1:0] ram_a_q;
    logic [7:0]        ram_dout_q;
    logic              ram_wr_q;

    logic mem_req, mem_own, mem_rd, mem_wr;
    logic if_pend, if_issue, rd_issue;

    always_comb begin
        mem_req  = (mem_rw_i == 2'b01) || (mem_rw_i == 2'b10);
        mem_own  = mem_req | lock_q;
        mem_rd   = mem_own & (mem_rw_i == 2'b01);
        mem_wr   = mem_own & (mem_rw_i == 2'b10);
        // IF port is non-pipelined: hold off re-issue while its read is still in flight
        if_pend  = (tag1_v_q & tag1_if_q) | (tag2_v_q & tag2_if_q);
        if_issue = if_rw_i & ~mem_own & ~if_pend;
        rd_issue = mem_rd | if_issue;
        if_busy_o = if_rw_i & mem_own;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q     <= 1'b0;
            tag1_v_q   <= 1'b0;
            tag1_if_q  <= 1'b0;
            tag2_v_q   <= 1'b0;
            tag2_if_q  <= 1'b0;
            mem_r_q    <= 1'b0;
            if_r_q     <= 1'b0;
            mem_data_q <= '0;
            if_data_q  <= '0;
            ram_a_q    <= '0;
            ram_dout_q <= '0;
            ram_wr_q   <= 1'b0;
        end else begin
            if (mem_own) begin
                lock_q <= mem_flag_i;
            end
            ram_wr_q <= mem_wr;
            if (mem_req) begin
                ram_a_q    <= mem_addr_i;
                ram_dout_q <= mem_data_i;
            end else if (if_issue) begin
                ram_a_q    <= if_addr_i;
            end
            tag1_v_q  <= rd_issue;
            tag1_if_q <= if_issue;
            tag2_v_q  <= tag1_v_q;
            tag2_if_q <= tag1_if_q;
            // RAM data for the tag2 read is valid in the current cycle
            mem_r_q <= tag2_v_q & ~tag2_if_q;
            if_r_q  <= tag2_v_q & tag2_if_q;
            if (tag2_v_q & ~tag2_if_q) begin
                mem_data_q <= ram_din_i;
            end
            if (tag2_v_q & tag2_if_q) begin
                if_data_q <= ram_din_i;
            end
        end
    end

    assign mem_r_o    = mem_r_q;
    assign mem_data_o = mem_data_q;
    assign if_r_o     = if_r_q;
    assign if_data_o  = if_data_q;
    assign ram_a_o    = ram_a_q;
    assign ram_dout_o = ram_dout_q;
    assign ram_wr_o   = ram_wr_q;

`ifdef MEM_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_rd_q, perf_wr_q, perf_conf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_rd_q   <= '0;
            perf_wr_q   <= '0;
            perf_conf_q <= '0;
        end else begin
            if (rd_issue) begin
                perf_rd_q <= perf_rd_q + CNT_W'(1);
            end
            if (mem_wr) begin
                perf_wr_q <= perf_wr_q + CNT_W'(1);
            end
            if (if_busy_o) begin
                perf_conf_q <= perf_conf_q + CNT_W'(1);
            end
        end
    end

    assign perf_rd_o   = perf_rd_q;
    assign perf_wr_o   = perf_wr_q;
    assign perf_conf_o = perf_conf_q;
`else
    assign perf_rd_o   = '0;
    assign perf_wr_o   = '0;
    assign perf_conf_o = '0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a behavioural 1-cycle-latency byte RAM.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mem_rw_i;
    logic [31:0] mem_addr_i;
    logic [7:0]  mem_data_i;
    logic        mem_flag_i;
    logic        mem_r_o;
    logic [7:0]  mem_data_o;
    logic        if_rw_i;
    logic [31:0] if_addr_i;
    logic        if_r_o;
    logic [7:0]  if_data_o;
    logic        if_busy_o;
    logic [7:0]  ram_din_i;
    logic [31:0] ram_a_o;
    logic [7:0]  ram_dout_o;
    logic        ram_wr_o;
    logic [31:0] perf_rd_o, perf_wr_o, perf_conf_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [0:1023];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr_o) ram[ram_a_o[9:0]] <= ram_dout_o;
        ram_din_i <= ram[ram_a_o[9:0]];
    end

    mem_ctrl #(.ADDR_W(32), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_rw_i   (mem_rw_i),
        .mem_addr_i (mem_addr_i),
        .mem_data_i (mem_data_i),
        .mem_flag_i (mem_flag_i),
        .mem_r_o    (mem_r_o),
        .mem_data_o (mem_data_o),
        .if_rw_i    (if_rw_i),
        .if_addr_i  (if_addr_i),
        .if_r_o     (if_r_o),
        .if_data_o  (if_data_o),
        .if_busy_o  (if_busy_o),
        .ram_din_i  (ram_din_i),
        .ram_a_o    (ram_a_o),
        .ram_dout_o (ram_dout_o),
        .ram_wr_o   (ram_wr_o),
        .perf_rd_o  (perf_rd_o),
        .perf_wr_o  (perf_wr_o),
        .perf_conf_o(perf_conf_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_rw_i   = 2'b00;
        mem_addr_i = '0;
        mem_data_i = '0;
        mem_flag_i = 1'b0;
        if_rw_i    = 1'b0;
        if_addr_i  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({mem_r_o, if_r_o, ram_wr_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses: got %b want 000", {mem_r_o, if_r_o, ram_wr_o});
        end
        checks++;
        if ({mem_data_o, if_data_o, ram_dout_o} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 000000", {mem_data_o, if_data_o, ram_dout_o});
        end
        checks++;
        if (ram_a_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_addr: got %h want 0", ram_a_o);
        end
        checks++;
        if ({perf_rd_o, perf_wr_o, perf_conf_o} !== 96'h0) begin
            errors++;
            $display("FAIL reset_perf: got %0d %0d %0d want 0 0 0", perf_rd_o, perf_wr_o, perf_conf_o);
        end
    endtask

    task automatic test_single_read();
        ram[10'h100] = 8'hA5;
        mem_rw_i = 2'b01; mem_addr_i = 32'h100; mem_flag_i = 1'b0;
        tick();
        mem_rw_i = 2'b00;
        checks++;
        if (ram_a_o !== 32'h100 || mem_r_o !== 1'b0) begin
            errors++;
            $display("FAIL single_issue: addr %h r %b want 100 0", ram_a_o, mem_r_o);
        end
        tick();
        checks++;
        if (mem_r_o !== 1'b0) begin
            errors++;
            $display("FAIL single_early: mem_r_o %b want 0", mem_r_o);
        end
        tick();
        checks++;
        if (mem_r_o !== 1'b1 || mem_data_o !== 8'hA5) begin
            errors++;
            $display("FAIL single_return: r %b data %h want 1 a5", mem_r_o, mem_data_o);
        end
        tick();
        checks++;
        if (mem_r_o !== 1'b0 || mem_data_o !== 8'hA5) begin
            errors++;
            $display("FAIL single_after: r %b data %h want 0 a5", mem_r_o, mem_data_o);
        end
    endtask

    task automatic test_burst_read();
        logic [7:0] exp [4];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
        for (int i = 0; i < 4; i++) ram[10'h200 + i] = exp[i];
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                mem_rw_i = 2'b01; mem_addr_i = 32'h200 + k; mem_flag_i = (k < 3);
                if_rw_i = 1'b1; if_addr_i = 32'h0;
            end else begin
                idle_inputs();
            end
            #1;
            if (k < 4) begin
                checks++;
                if (if_busy_o !== 1'b1) begin
                    errors++;
                    $display("FAIL burst_busy[%0d]: got %b want 1", k, if_busy_o);
                end
            end
            tick();
            if (k >= 2 && k <= 5) begin
                checks++;
                if (mem_r_o !== 1'b1 || mem_data_o !== exp[k-2]) begin
                    errors++;
                    $display("FAIL burst_ret[%0d]: r %b data %h want 1 %h", k, mem_r_o, mem_data_o, exp[k-2]);
                end
            end else begin
                checks++;
                if (mem_r_o !== 1'b0 || if_r_o !== 1'b0) begin
                    errors++;
                    $display("FAIL burst_quiet[%0d]: mem_r %b if_r %b want 0 0", k, mem_r_o, if_r_o);
                end
            end
        end
    endtask

    task automatic test_write_word();
        logic [7:0] wd [4];
        wd[0] = 8'hDE; wd[1] = 8'hAD; wd[2] = 8'hBE; wd[3] = 8'hEF;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                mem_rw_i = 2'b10; mem_addr_i = 32'h300 + k; mem_data_i = wd[k]; mem_flag_i = (k < 3);
            end else begin
                idle_inputs();
            end
            tick();
            checks++;
            if (ram_wr_o !== (k < 4) || mem_r_o !== 1'b0 || if_r_o !== 1'b0) begin
                errors++;
                $display("FAIL write_ctl[%0d]: wr %b mem_r %b if_r %b want %b 0 0", k, ram_wr_o, mem_r_o, if_r_o, k < 4);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ram[10'h300 + i] !== wd[i]) begin
                errors++;
                $display("FAIL write_ram[%0d]: got %h want %h", i, ram[10'h300 + i], wd[i]);
            end
        end
    endtask

    task automatic test_conflict();
        int busy_cnt = 0, mem_cnt = 0, if_cnt = 0, mem_at = -1, if_at = -1;
        logic [7:0] mem_got = 8'h00, if_got = 8'h00;
        ram[10'h000] = 8'h5A;
        ram[10'h040] = 8'hC3;
        if_rw_i = 1'b1; if_addr_i = 32'h0;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin
                mem_rw_i = 2'b01; mem_addr_i = 32'h40; mem_flag_i = 1'b0;
            end else begin
                mem_rw_i = 2'b00;
            end
            #1;
            if (if_busy_o === 1'b1) busy_cnt++;
            tick();
            if (k == 0) begin
                checks++;
                if (ram_a_o !== 32'h40) begin
                    errors++;
                    $display("FAIL conflict_mem_first: addr %h want 40", ram_a_o);
                end
            end
            if (k == 1) begin
                checks++;
                if (ram_a_o !== 32'h0) begin
                    errors++;
                    $display("FAIL conflict_if_second: addr %h want 0", ram_a_o);
                end
            end
            if (mem_r_o === 1'b1) begin mem_cnt++; mem_at = k; mem_got = mem_data_o; end
            if (if_r_o === 1'b1) begin if_cnt++; if_at = k; if_got = if_data_o; if_rw_i = 1'b0; end
        end
        checks++;
        if (busy_cnt != 1) begin
            errors++;
            $display("FAIL conflict_busy: %0d cycles want 1", busy_cnt);
        end
        checks++;
        if (mem_cnt != 1 || mem_at != 2 || mem_got !== 8'hC3) begin
            errors++;
            $display("FAIL conflict_mem_ret: cnt %0d at %0d data %h want 1 2 c3", mem_cnt, mem_at, mem_got);
        end
        checks++;
        if (if_cnt != 1 || if_at != 3 || if_got !== 8'h5A) begin
            errors++;
            $display("FAIL conflict_if_ret: cnt %0d at %0d data %h want 1 3 5a", if_cnt, if_at, if_got);
        end
    endtask

    task automatic test_reset_inflight();
        int pulses = 0;
        mem_rw_i = 2'b01; mem_addr_i = 32'h100; mem_flag_i = 1'b0;
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({mem_r_o, if_r_o, ram_wr_o} !== 3'b000 || mem_data_o !== 8'h00 || ram_a_o !== 32'h0) begin
            errors++;
            $display("FAIL inflight_reset: r %b data %h addr %h want 0 00 0", mem_r_o, mem_data_o, ram_a_o);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            if (mem_r_o === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL inflight_drop: %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_perf();
        logic [1:0] ops [5];
        int exp_rd, exp_wr, exp_conf;
        ops[0] = 2'b01; ops[1] = 2'b01; ops[2] = 2'b01; ops[3] = 2'b10; ops[4] = 2'b10;
`ifdef MEM_CTRL_PERF_EN
        exp_rd = 3; exp_wr = 2; exp_conf = 5;
`else
        exp_rd = 0; exp_wr = 0; exp_conf = 0;
`endif
        do_reset();
        for (int k = 0; k < 5; k++) begin
            mem_rw_i = ops[k]; mem_addr_i = 32'h380 + k; mem_data_i = 8'h60 + 8'(k); mem_flag_i = (k < 4);
            if_rw_i = 1'b1; if_addr_i = 32'h4;
            tick();
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (perf_rd_o !== 32'(exp_rd)) begin
            errors++;
            $display("FAIL perf_rd: got %0d want %0d", perf_rd_o, exp_rd);
        end
        checks++;
        if (perf_wr_o !== 32'(exp_wr)) begin
            errors++;
            $display("FAIL perf_wr: got %0d want %0d", perf_wr_o, exp_wr);
        end
        checks++;
        if (perf_conf_o !== 32'(exp_conf)) begin
            errors++;
            $display("FAIL perf_conf: got %0d want %0d", perf_conf_o, exp_conf);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_burst_read();
        test_write_word();
        test_conflict();
        test_reset_inflight();
        test_perf();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
